// File: rtl/pipe_pkg.sv
// Shared types and defaults for the MEM/WB pipeline stage.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

   localparam int WB_REGWRITE = 0;
   localparam int WB_MEMTOREG = 1;

endpackage

// File: rtl/pipe_entry_reg.sv
// One payload register of the stage: load enable, cleared by async reset.
module pipe_entry_reg #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         ld_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] q_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)    q_q <= '0;
      else if (ld_i) q_q <= d_i;
   end

   assign q_o = q_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: valid/ready handshake with a main + skid entry, flush,
// bubble insertion on empty, and a saturating stall-cycle counter.
//
// state    | meaning
// ST_EMPTY | no entry held, outputs show a bubble
// ST_ONE   | main entry valid, skid free, ready_o=1
// ST_FULL  | main and skid both valid, ready_o=0
module mem_wb_stage
   import pipe_pkg::*;
#(
   parameter int                 INST_W   = 32,
   parameter int                 CTRL_W   = 2,
   parameter int                 DATA_W   = 32,
   parameter int                 NUM_DATA = 2,
   parameter logic [INST_W-1:0]  NOP_INST = INST_W'(NOP_INST_DEF),
   parameter int                 CNT_W    = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       valid_i,
   output logic                       ready_o,
   input  logic [INST_W-1:0]          inst_i,
   input  logic [CTRL_W-1:0]          WB_signal_i,
   input  logic [NUM_DATA*DATA_W-1:0] data_i,
   input  logic                       flush_i,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [INST_W-1:0]          inst_o,
   output logic [CTRL_W-1:0]          WB_signal_o,
   output logic [NUM_DATA*DATA_W-1:0] data_o,
   output logic [CNT_W-1:0]           stall_cnt_o
);

   localparam int DW = NUM_DATA * DATA_W;
   localparam int PW = INST_W + CTRL_W + DW;

   state_e          state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            accept, drain;
   logic            main_ld, skid_ld, skid_to_main;
   logic [PW-1:0]   in_pl, main_in, main_q, skid_q;
   logic [INST_W-1:0] m_inst;
   logic [CTRL_W-1:0] m_wb;
   logic [DW-1:0]     m_data;

   assign valid_o = (state_q != ST_EMPTY);
   assign ready_o = (state_q != ST_FULL);
   assign accept  = valid_i & ready_o;
   assign drain   = valid_o & ready_i;

   always_comb begin
      state_d      = state_q;
      main_ld      = 1'b0;
      skid_ld      = 1'b0;
      skid_to_main = 1'b0;
      case (state_q)
         ST_EMPTY: if (accept) begin
            state_d = ST_ONE;
            main_ld = 1'b1;
         end
         ST_ONE: begin
            if (accept && drain) begin
               main_ld = 1'b1;
            end else if (accept) begin
               state_d = ST_FULL;
               skid_ld = 1'b1;
            end else if (drain) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: if (drain) begin
            state_d      = ST_ONE;
            main_ld      = 1'b1;
            skid_to_main = 1'b1;
         end
         default: state_d = ST_EMPTY;
      endcase
      // Flush wins over everything, including a same-cycle accept.
      if (flush_i) begin
         state_d = ST_EMPTY;
         main_ld = 1'b0;
         skid_ld = 1'b0;
      end
   end

   assign cnt_d = (valid_o && !ready_i && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_EMPTY;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_pl   = {inst_i, WB_signal_i, data_i};
   assign main_in = skid_to_main ? skid_q : in_pl;

   pipe_entry_reg #(.W(PW)) u_main (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .ld_i  (main_ld),
      .d_i   (main_in),
      .q_o   (main_q)
   );

   pipe_entry_reg #(.W(PW)) u_skid (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .ld_i  (skid_ld),
      .d_i   (in_pl),
      .q_o   (skid_q)
   );

   assign {m_inst, m_wb, m_data} = main_q;

   // Bubble: zero control so an empty stage can never write the register file.
   assign inst_o      = valid_o ? m_inst : NOP_INST;
   assign WB_signal_o = valid_o ? m_wb   : '0;
   assign data_o      = valid_o ? m_data : '0;
   assign stall_cnt_o = cnt_q;

endmodule
